// File: rtl/matrix_mac_sequencer.sv
// Sequencer that walks two 3x3 row-major matrices held in external memories,
// multiply-accumulates each dot product over three cycles and writes the
// saturated element to a result memory. One run covers 9 elements x 4 cycles,
// followed by a single DONE cycle.
module matrix_mac_sequencer #(
    parameter int DW   = 18,
    parameter int ACCW = 38
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [4:0]    a_addr,
    output logic          a_read,
    input  logic [DW-1:0] a_data,
    output logic [4:0]    b_addr,
    output logic          b_read,
    input  logic [DW-1:0] b_data,
    output logic [4:0]    c_addr,
    output logic          c_write,
    output logic [DW-1:0] c_data
);

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StWrite,
        StDone
    } state_e;

    // Clamp bounds of the DW-bit signed result, expressed at accumulator width.
    localparam logic signed [ACCW-1:0] SatMax = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SatMin = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    state_e                 state_q;
    logic [1:0]             row_q;
    logic [1:0]             col_q;
    logic [1:0]             k_q;
    logic signed [ACCW-1:0] acc_q;

    logic signed [ACCW-1:0] a_ext;
    logic signed [ACCW-1:0] b_ext;
    logic signed [ACCW-1:0] prod;
    logic signed [ACCW-1:0] acc_sum;
    logic signed [ACCW-1:0] acc_sat;
    logic [4:0]             row_x3;
    logic [4:0]             k_inc;
    logic [4:0]             k_inc_x3;
    logic [1:0]             row_nxt;
    logic [1:0]             col_nxt;
    logic [4:0]             row_nxt_x3;

    // Datapath: sign-extended product, accumulate (restart on k=0), saturate.
    always_comb begin
        a_ext   = {{(ACCW-DW){a_data[DW-1]}}, a_data};
        b_ext   = {{(ACCW-DW){b_data[DW-1]}}, b_data};
        prod    = a_ext * b_ext;
        acc_sum = ((k_q == 2'd0) ? '0 : acc_q) + prod;
        if (acc_sum > SatMax) begin
            acc_sat = SatMax;
        end else if (acc_sum < SatMin) begin
            acc_sat = SatMin;
        end else begin
            acc_sat = acc_sum;
        end
    end

    // Address arithmetic for the next cycle's registered outputs.
    always_comb begin
        row_x3     = ({3'b000, row_q} << 1) + {3'b000, row_q};
        k_inc      = {3'b000, k_q} + 5'd1;
        k_inc_x3   = (k_inc << 1) + k_inc;
        col_nxt    = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
        row_nxt    = (col_q == 2'd2) ? row_q + 2'd1 : row_q;
        row_nxt_x3 = ({3'b000, row_nxt} << 1) + {3'b000, row_nxt};
    end

    // FSM with counters, accumulator and all outputs registered; each branch
    // loads the outputs that belong to the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            row_q   <= 2'd0;
            col_q   <= 2'd0;
            k_q     <= 2'd0;
            acc_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            a_addr  <= 5'd0;
            a_read  <= 1'b0;
            b_addr  <= 5'd0;
            b_read  <= 1'b0;
            c_addr  <= 5'd0;
            c_write <= 1'b0;
            c_data  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StMac;
                        row_q   <= 2'd0;
                        col_q   <= 2'd0;
                        k_q     <= 2'd0;
                        busy    <= 1'b1;
                        a_read  <= 1'b1;
                        b_read  <= 1'b1;
                        a_addr  <= 5'd0;
                        b_addr  <= 5'd0;
                    end
                end
                StMac: begin
                    acc_q <= acc_sum;
                    if (k_q == 2'd2) begin
                        state_q <= StWrite;
                        k_q     <= 2'd0;
                        a_read  <= 1'b0;
                        b_read  <= 1'b0;
                        a_addr  <= 5'd0;
                        b_addr  <= 5'd0;
                        c_write <= 1'b1;
                        c_addr  <= row_x3 + {3'b000, col_q};
                        c_data  <= acc_sat[DW-1:0];
                    end else begin
                        k_q    <= k_q + 2'd1;
                        a_addr <= row_x3 + k_inc;
                        b_addr <= k_inc_x3 + {3'b000, col_q};
                    end
                end
                StWrite: begin
                    c_write <= 1'b0;
                    c_addr  <= 5'd0;
                    c_data  <= '0;
                    if (row_q == 2'd2 && col_q == 2'd2) begin
                        state_q <= StDone;
                        done    <= 1'b1;
                    end else begin
                        state_q <= StMac;
                        row_q   <= row_nxt;
                        col_q   <= col_nxt;
                        k_q     <= 2'd0;
                        a_read  <= 1'b1;
                        b_read  <= 1'b1;
                        a_addr  <= row_nxt_x3;
                        b_addr  <= {3'b000, col_nxt};
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    row_q   <= 2'd0;
                    col_q   <= 2'd0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_mac_sequencer.sv
// Bench for matrix_mac_sequencer: behavioural memories plus a plain-arithmetic
// matrix product model; each scenario task checks writes, timing and idle values.
module tb_matrix_mac_sequencer;

    localparam int DW   = 18;
    localparam int ACCW = 38;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done;
    logic [4:0]    a_addr, b_addr, c_addr;
    logic          a_read, b_read, c_write;
    logic [DW-1:0] a_data, b_data, c_data;

    logic signed [DW-1:0] a_mem [9];
    logic signed [DW-1:0] b_mem [9];

    int total = 0;
    int bad   = 0;

    // Observation state, cleared per scenario.
    int            wr_addr [$];
    logic [DW-1:0] wr_data [$];
    int            done_at [$];
    int            busy_cnt;
    int            proto_err;

    always #5 clk = ~clk;

    // Memories drive a junk pattern when not read, so a missing enable shows up.
    assign a_data = (a_read && a_addr < 9) ? a_mem[a_addr] : 18'h2AAAA;
    assign b_data = (b_read && b_addr < 9) ? b_mem[b_addr] : 18'h15555;

    matrix_mac_sequencer #(.DW(DW), .ACCW(ACCW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .a_addr  (a_addr),
        .a_read  (a_read),
        .a_data  (a_data),
        .b_addr  (b_addr),
        .b_read  (b_read),
        .b_data  (b_data),
        .c_addr  (c_addr),
        .c_write (c_write),
        .c_data  (c_data)
    );

    function automatic logic signed [DW-1:0] model_c(input int e);
        longint s = 0;
        longint mx = (longint'(1) <<< (DW - 1)) - 1;
        longint mn = -(longint'(1) <<< (DW - 1));
        int r = e / 3;
        int c = e % 3;
        for (int k = 0; k < 3; k++) s += longint'(a_mem[3*r+k]) * longint'(b_mem[3*k+c]);
        if (s > mx) s = mx;
        if (s < mn) s = mn;
        return s[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] small_val();
        int v = int'($urandom_range(0, 2000)) - 1000;
        return v[DW-1:0];
    endfunction

    task automatic clear_obs();
        wr_addr.delete();
        wr_data.delete();
        done_at.delete();
        busy_cnt  = 0;
        proto_err = 0;
    endtask

    // Called at a negedge; n is the cycle number relative to the start edge.
    task automatic observe(input int n);
        if (c_write) begin
            wr_addr.push_back(int'(c_addr));
            wr_data.push_back(c_data);
        end
        if (done) done_at.push_back(n);
        if (busy) busy_cnt++;
        if (a_addr > 8 || b_addr > 8 || c_addr > 8) proto_err++;
        if (c_write && (a_read || b_read)) proto_err++;
        if (!a_read && (a_addr != 0 || b_addr != 0 || b_read)) proto_err++;
        if (!c_write && (c_addr != 0 || c_data != 0)) proto_err++;
    endtask

    task automatic do_reset();
        start = 1'b0;
        rst   = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    // Drives start so it is sampled at the next edge (T0); returns just after T0.
    task automatic pulse_start(input bit hold);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 if (!hold) start = 1'b0;
    endtask

    // Checks a single run's writes against the model starting at element 0.
    task automatic check_run(input string name, input int exp_done);
        total++;
        if (wr_addr.size() != 9) begin
            bad++;
            $display("FAIL %s write_count got=%0d exp=9", name, wr_addr.size());
        end
        for (int i = 0; i < 9 && i < wr_addr.size(); i++) begin
            total++;
            if (wr_addr[i] !== i || wr_data[i] !== model_c(i)) begin
                bad++;
                $display("FAIL %s elem%0d got addr=%0d data=%0d exp addr=%0d data=%0d", name,
                         i, wr_addr[i], $signed(wr_data[i]), i, $signed(model_c(i)));
            end
        end
        total++;
        if (done_at.size() != 1 || done_at[0] !== exp_done) begin
            bad++;
            $display("FAIL %s done_timing got count=%0d first=%0d exp count=1 at=%0d", name,
                     done_at.size(), (done_at.size() > 0) ? done_at[0] : -1, exp_done);
        end
        total++;
        if (busy_cnt !== 37) begin
            bad++;
            $display("FAIL %s busy_cycles got=%0d exp=37", name, busy_cnt);
        end
        total++;
        if (proto_err !== 0) begin
            bad++;
            $display("FAIL %s idle_values got=%0d violations exp=0", name, proto_err);
        end
    endtask

    task automatic single_run(input string name);
        do_reset();
        clear_obs();
        pulse_start(1'b0);
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            observe(n);
        end
        check_run(name, 37);
    endtask

    task automatic test_reset();
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({busy, done, a_addr, a_read, b_addr, b_read, c_addr, c_write, c_data} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got busy=%b done=%b a=%0d b=%0d c=%0d w=%b exp all 0",
                     busy, done, a_addr, b_addr, c_addr, c_write);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_obs();
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            observe(n);
        end
        total++;
        if (busy_cnt !== 0 || done_at.size() !== 0 || wr_addr.size() !== 0) begin
            bad++;
            $display("FAIL reset_idle got busy=%0d done=%0d writes=%0d exp 0 0 0",
                     busy_cnt, done_at.size(), wr_addr.size());
        end
    endtask

    task automatic test_identity();
        for (int i = 0; i < 9; i++) begin
            a_mem[i] = (i % 4 == 0) ? 18'sd1 : 18'sd0;
            b_mem[i] = 18'(i + 1);
        end
        single_run("identity");
        for (int i = 0; i < 9 && i < wr_data.size(); i++) begin
            total++;
            if ($signed(wr_data[i]) !== i + 1) begin
                bad++;
                $display("FAIL identity_const%0d got=%0d exp=%0d", i, $signed(wr_data[i]), i + 1);
            end
        end
    endtask

    task automatic test_ones();
        for (int i = 0; i < 9; i++) begin
            a_mem[i] = 18'sd1;
            b_mem[i] = 18'sd2;
        end
        single_run("ones");
        total++;
        if (wr_data.size() < 1 || $signed(wr_data[0]) !== 6) begin
            bad++;
            $display("FAIL ones_const got=%0d exp=6", (wr_data.size() > 0) ? $signed(wr_data[0]) : 0);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 9; i++) begin
            a_mem[i] = 18'sd131071;
            b_mem[i] = 18'sd131071;
        end
        single_run("sat_pos");
        total++;
        if (wr_data.size() < 9 || $signed(wr_data[8]) !== 131071) begin
            bad++;
            $display("FAIL sat_pos_const got=%0d exp=131071",
                     (wr_data.size() > 8) ? $signed(wr_data[8]) : 0);
        end
        for (int i = 0; i < 9; i++) begin
            a_mem[i] = -18'sd131072;
            b_mem[i] = 18'sd131071;
        end
        single_run("sat_neg");
        total++;
        if (wr_data.size() < 9 || $signed(wr_data[4]) !== -131072) begin
            bad++;
            $display("FAIL sat_neg_const got=%0d exp=-131072",
                     (wr_data.size() > 4) ? $signed(wr_data[4]) : 0);
        end
    endtask

    task automatic test_mixed_sign();
        for (int i = 0; i < 9; i++) begin
            a_mem[i] = small_val();
            b_mem[i] = small_val();
        end
        a_mem[0] = -18'sd1;  a_mem[1] = 18'sd2;  a_mem[2] = -18'sd3;
        b_mem[0] = 18'sd4;   b_mem[3] = -18'sd5; b_mem[6] = 18'sd6;
        single_run("mixed");
        total++;
        if (wr_data.size() < 1 || $signed(wr_data[0]) !== -32) begin
            bad++;
            $display("FAIL mixed_c00 got=%0d exp=-32",
                     (wr_data.size() > 0) ? $signed(wr_data[0]) : 0);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 9; i++) begin
                a_mem[i] = (it < 2) ? small_val() : 18'($urandom);
                b_mem[i] = (it < 2) ? small_val() : 18'($urandom);
            end
            single_run($sformatf("random%0d", it));
        end
    endtask

    task automatic test_reset_mid_run();
        for (int i = 0; i < 9; i++) begin
            a_mem[i] = small_val();
            b_mem[i] = small_val();
        end
        do_reset();
        clear_obs();
        pulse_start(1'b0);
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            observe(n);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        for (int n = 0; n < 3; n++) begin
            #1;
            total++;
            if ({busy, done, a_addr, a_read, b_addr, b_read, c_addr, c_write, c_data} !== '0) begin
                bad++;
                $display("FAIL midrst_outputs%0d got busy=%b a=%0d b=%0d w=%b exp all 0",
                         n, busy, a_addr, b_addr, c_write);
            end
            @(negedge clk);
        end
        rst = 1'b0;
        for (int n = 10; n <= 60; n++) begin
            @(negedge clk);
            observe(n);
        end
        total++;
        if (wr_addr.size() !== 2 || done_at.size() !== 0) begin
            bad++;
            $display("FAIL midrst_abort got writes=%0d dones=%0d exp writes=2 dones=0",
                     wr_addr.size(), done_at.size());
        end
        total++;
        if (busy_cnt !== 9) begin
            bad++;
            $display("FAIL midrst_no_resume got busy_cycles=%0d exp=9", busy_cnt);
        end
    endtask

    task automatic test_start_ignored();
        for (int i = 0; i < 9; i++) begin
            a_mem[i] = small_val();
            b_mem[i] = small_val();
        end
        do_reset();
        clear_obs();
        pulse_start(1'b0);
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            observe(n);
            start = (n == 4);
        end
        total++;
        if (done_at.size() !== 1 || wr_addr.size() !== 9) begin
            bad++;
            $display("FAIL start_ignored got dones=%0d writes=%0d exp dones=1 writes=9",
                     done_at.size(), wr_addr.size());
        end
        check_run("start_ignored", 37);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 9; i++) begin
            a_mem[i] = 18'($urandom);
            b_mem[i] = small_val();
        end
        do_reset();
        clear_obs();
        pulse_start(1'b1);
        for (int n = 1; n <= 120; n++) begin
            @(negedge clk);
            observe(n);
            if (n == 113) start = 1'b0;
        end
        total++;
        if (done_at.size() !== 3 || done_at[0] !== 37 || done_at[1] !== 75 || done_at[2] !== 113)
        begin
            bad++;
            $display("FAIL b2b_done_spacing got count=%0d first=%0d exp 3 at 37,75,113",
                     done_at.size(), (done_at.size() > 0) ? done_at[0] : -1);
        end
        total++;
        if (wr_addr.size() !== 27 || busy_cnt !== 111) begin
            bad++;
            $display("FAIL b2b_counts got writes=%0d busy=%0d exp writes=27 busy=111",
                     wr_addr.size(), busy_cnt);
        end
        for (int i = 0; i < 27 && i < wr_addr.size(); i++) begin
            total++;
            if (wr_addr[i] !== i % 9 || wr_data[i] !== model_c(i % 9)) begin
                bad++;
                $display("FAIL b2b_elem%0d got addr=%0d data=%0d exp addr=%0d data=%0d", i,
                         wr_addr[i], $signed(wr_data[i]), i % 9, $signed(model_c(i % 9)));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 9; i++) begin
            a_mem[i] = '0;
            b_mem[i] = '0;
        end
        do_reset();
        test_reset();
        test_identity();
        test_ones();
        test_saturation();
        test_mixed_sign();
        test_random();
        test_reset_mid_run();
        test_start_ignored();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matrix_mac_sequencer.md
MATRIX_MAC_SEQUENCER -- requirements
Module: matrix_mac_sequencer

Interface
REQ-001 Parameter DW, default 18, the element width in bits (signed two's complement).
REQ-002 Parameter ACCW, default 38, the accumulator width in bits (2*DW+2).
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 start  input  1  run request; sampled only in IDLE.
REQ-006 busy  output  1  high from the first MAC cycle through the DONE cycle.
REQ-007 done  output  1  one-cycle pulse when all 9 results are written.
REQ-008 a_addr  output  5  read address to the matrix-A memory; range 0..8.
REQ-009 a_read  output  1  read enable to the matrix-A memory.
REQ-010 a_data  input  DW  combinational read data from the A memory, valid in the same cycle.
REQ-011 b_addr, b_read, b_data  out/out/in  5/1/DW  same as a_*, for the matrix-B memory.
REQ-012 c_addr  output  5  write address to the result memory; range 0..8.
REQ-013 c_write  output  1  write strobe to the result memory.
REQ-014 c_data  output  DW  saturated result element.

Function
REQ-015 Computes C = A x B for 3x3 matrices stored row-major: element (r,c) sits at address 3r+c.
REQ-016 FSM states are IDLE, MAC, WRITE and DONE.
REQ-017 IDLE -> MAC on a rising edge where start=1; otherwise the FSM stays in IDLE.
REQ-018 Element order is e = 0..8, with i = e/3 and j = e%3; each element uses 3 MAC cycles (k = 0,1,2) followed by 1 WRITE cycle.
REQ-019 MAC cycle, addressing: a_read=b_read=1, a_addr=3i+k, b_addr=3k+j.
REQ-020 MAC cycle, accumulation: at the edge, acc <= (k==0 ? 0 : acc) + sext(a_data)*sext(b_data), computed at full ACCW width with no overflow.
REQ-021 WRITE cycle: c_write=1, c_addr=3i+j, c_data=sat(acc); the read enables are 0.
REQ-022 Next state after WRITE: MAC for element e+1 if e<8; DONE if e=8.
REQ-023 DONE: done=1 and busy=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-024 sat() clamps acc to [-2^(DW-1), 2^(DW-1)-1], i.e. [-131072, 131071] for DW=18; values in range pass through unchanged.
REQ-025 Timing: start is sampled at edge T0; element e occupies cycles T0+4e+1..T0+4e+4; the last write is in cycle T0+36; done is in cycle T0+37; IDLE is re-entered at T0+38.
REQ-026 start asserted while not in IDLE is ignored; it is neither queued nor allowed to restart the sequence.
REQ-027 start held high continuously gives back-to-back runs: the next run's start is sampled in the IDLE cycle at T0+38.
REQ-028 Outside MAC cycles, a_addr, b_addr, a_read and b_read are 0.
REQ-029 Outside WRITE cycles, c_addr, c_write and c_data are 0.
REQ-030 All outputs are registered or decoded from registered state only; there are no combinational paths from inputs to outputs.
REQ-031 Exactly 9 c_write pulses per run, to addresses 0..8 in ascending order.
REQ-032 No address output ever exceeds 8.

Reset
REQ-033 While rst=1, all of the following are forced immediately and held: state=IDLE, element and k counters 0, acc 0, all outputs 0.
REQ-034 rst asserted mid-run aborts the run: no further c_write and no done for that run.
REQ-035 After rst deasserts, a new start is required to begin a run; there is no resume.

Verification
REQ-036 A = identity, B = [1..9], pulse start -> c_data at addresses 0..8 is 1..9 in order, and done appears exactly 37 cycles after the start edge.
REQ-037 A = all 1, B = all 2 -> all 9 writes are 6; busy is high for 37 cycles.
REQ-038 Saturation: A = B = all 131071 -> all writes are 131071. A = all -131072, B = all 131071 -> all writes are -131072.
REQ-039 Mixed signs: A row 0 = [-1,2,-3], B column 0 = [4,-5,6] -> C(0,0) = -32.
REQ-040 Reset mid-run: assert rst at cycle T0+10 -> c_write count stops at 2, done never pulses, and all outputs are 0 during reset.
REQ-041 Start handling: start held high -> done pulses every 38 cycles. A 1-cycle start pulse at T0+5 -> ignored, exactly one done.
